// File: rtl/seq2b_autoplayer.sv
// Automatic player for the seq2b8lv memory game: records the symbols shown on
// the light bus, then replays them on the button bus once per round.
module seq2b_autoplayer #(
    parameter int unsigned MAX_LEN = 8,
    parameter int unsigned GAP_END = 4,
    parameter int unsigned PRESS   = 2,
    parameter int unsigned RELEASE = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       inject_err,
    input  logic [3:0] l,
    input  logic       win,
    input  logic       lose,
    output logic [3:0] b,
    output logic       busy,
    output logic [3:0] len,
    output logic [3:0] rounds,
    output logic       ovf,
    output logic       bad_l
);

    localparam int unsigned IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LISTEN,
        ST_PRESS,
        ST_GAP,
        ST_HALT
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  l_prev_q, l_prev_d;
    logic [1:0]  sym_buf_q [MAX_LEN];
    logic [1:0]  sym_buf_d [MAX_LEN];
    logic [3:0]  len_q, len_d;
    logic [3:0]  rd_q, rd_d;
    logic [7:0]  zero_cnt_q, zero_cnt_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        err_q, err_d;
    logic [3:0]  rounds_q, rounds_d;
    logic        ovf_q, ovf_d;
    logic        bad_l_q, bad_l_d;
    logic [3:0]  b_q, b_d;
    logic        busy_q, busy_d;
    logic        l_onehot;
    logic [1:0]  l_sym;
    logic [1:0]  rd_sym;

    function automatic logic [3:0] onehot(input logic [1:0] s);
        return 4'b0001 << s;
    endfunction

    always_comb begin
        l_onehot = 1'b1;
        l_sym    = 2'd0;
        case (l)
            4'b0001: l_sym = 2'd0;
            4'b0010: l_sym = 2'd1;
            4'b0100: l_sym = 2'd2;
            4'b1000: l_sym = 2'd3;
            default: l_onehot = 1'b0;
        endcase
    end

    // The last symbol of an error-injected replay is inverted.
    always_comb begin
        rd_sym = sym_buf_q[rd_q[IW-1:0]];
        if (err_q && (rd_q == len_q - 4'd1)) begin
            rd_sym = rd_sym ^ 2'b11;
        end
    end

    always_comb begin
        state_d    = state_q;
        l_prev_d   = l;
        sym_buf_d  = sym_buf_q;
        len_d      = len_q;
        rd_d       = rd_q;
        zero_cnt_d = '0;
        cnt_d      = cnt_q;
        err_d      = err_q;
        rounds_d   = rounds_q;
        ovf_d      = ovf_q;
        bad_l_d    = bad_l_q;
        b_d        = '0;

        if (!en) begin
            state_d = ST_IDLE;
            len_d   = '0;
        end else if (win || lose) begin
            state_d = ST_HALT;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    len_d   = '0;
                    state_d = ST_LISTEN;
                end
                ST_LISTEN: begin
                    if (l == 4'b0000) begin
                        zero_cnt_d = zero_cnt_q;
                        if (len_q != 4'd0) begin
                            if (zero_cnt_q == 8'(GAP_END - 1)) begin
                                state_d    = ST_PRESS;
                                rd_d       = '0;
                                cnt_d      = '0;
                                err_d      = inject_err;
                                zero_cnt_d = '0;
                            end else begin
                                zero_cnt_d = zero_cnt_q + 8'd1;
                            end
                        end
                    end else if (!l_onehot) begin
                        bad_l_d = 1'b1;
                    end else if (l != l_prev_q) begin
                        if (len_q < 4'(MAX_LEN)) begin
                            sym_buf_d[len_q[IW-1:0]] = l_sym;
                            len_d = len_q + 4'd1;
                        end else begin
                            ovf_d = 1'b1;
                        end
                    end
                end
                ST_PRESS: begin
                    b_d = onehot(rd_sym);
                    if (cnt_q == 8'(PRESS - 1)) begin
                        cnt_d   = '0;
                        state_d = ST_GAP;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                ST_GAP: begin
                    if (cnt_q == 8'(RELEASE - 1)) begin
                        cnt_d = '0;
                        if (rd_q + 4'd1 == len_q) begin
                            if (rounds_q != 4'hF) begin
                                rounds_d = rounds_q + 4'd1;
                            end
                            len_d   = '0;
                            state_d = ST_LISTEN;
                        end else begin
                            rd_d    = rd_q + 4'd1;
                            state_d = ST_PRESS;
                        end
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                default: state_d = ST_HALT;
            endcase
        end

        busy_d = (state_d == ST_LISTEN) || (state_d == ST_PRESS) || (state_d == ST_GAP);
    end

    always_ff @(posedge clk) begin
        sym_buf_q <= sym_buf_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            l_prev_q   <= '0;
            len_q      <= '0;
            rd_q       <= '0;
            zero_cnt_q <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            rounds_q   <= '0;
            ovf_q      <= 1'b0;
            bad_l_q    <= 1'b0;
            b_q        <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            l_prev_q   <= l_prev_d;
            len_q      <= len_d;
            rd_q       <= rd_d;
            zero_cnt_q <= zero_cnt_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            rounds_q   <= rounds_d;
            ovf_q      <= ovf_d;
            bad_l_q    <= bad_l_d;
            b_q        <= b_d;
            busy_q     <= busy_d;
        end
    end

    assign b      = b_q;
    assign busy   = busy_q;
    assign len    = len_q;
    assign rounds = rounds_q;
    assign ovf    = ovf_q;
    assign bad_l  = bad_l_q;

endmodule

// File: doc/seq2b_autoplayer.md
Name: seq2b_autoplayer

Overview:
- Automatic player for the seq2b8lv 2-bit / 8-level sequence memory game; it drives the game's buttons from the game's lights.
- Watches the game's light bus l, records each displayed 2-bit symbol, then replays the recorded sequence on the button bus b.
- Repeats once per round until the game asserts win or lose.
- Used in closed-loop benches and on the demo board to play the game hands-free. inject_err forces a wrong replay so the lose path can be exercised.

Parameters:
- MAX_LEN, 8, maximum stored symbols per round (matches 8 levels).
- GAP_END, 4, consecutive cycles of l==0 (after at least one symbol) that end the show phase.
- PRESS, 2, cycles each button is held.
- RELEASE, 2, cycles b is held at 0 between presses.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- en  input  1  enables play; low returns the block to IDLE.
- inject_err  input  1  sampled on entry to replay; if 1, the last symbol of that replay is inverted (xor 2'b11).
- l  input  4  game lights, one-hot symbol or 0.
- win  input  1  game won.
- lose  input  1  game lost.
- b  output  4  button drive, one-hot or 0.
- busy  output  1  high in LISTEN/PRESS/GAP.
- len  output  4  symbols recorded in the current round (0..MAX_LEN).
- rounds  output  4  completed replays, saturating at 15.
- ovf  output  1  sticky; a symbol arrived with len==MAX_LEN.
- bad_l  output  1  sticky; l was non-zero and not one-hot.

Behaviour:
- Symbol map: 0<->0001, 1<->0010, 2<->0100, 3<->1000.
- Reset (reset==0, asynchronous):
  - state=IDLE.
  - b=0, busy=0, len=0, rounds=0, ovf=0, bad_l=0.
  - Symbol buffer contents don't-care.
  - Reset mid-replay drops b to 0 immediately, without waiting for a clock edge.
- Priority each cycle: reset > en==0 (go to IDLE, b=0; rounds/ovf/bad_l hold) > win|lose (go to HALT) > normal transitions.
- IDLE:
  - b=0, len=0.
  - en==1 -> LISTEN next cycle.
- LISTEN:
  - Registered l_prev is used for edge detection.
  - Capture: when l is one-hot and l != l_prev:
    - if len<MAX_LEN, store its symbol at index len and increment len;
    - otherwise set ovf and drop the symbol.
  - Non-zero, non-one-hot l: set bad_l and ignore it.
  - zero_cnt increments while l==0 and len>0, and resets to 0 on any non-zero l.
  - When zero_cnt reaches GAP_END-1 with l==0: go to PRESS, rd=0, and latch inject_err into err_q.
- PRESS:
  - b = onehot(buf[rd]), except when err_q && rd==len-1, where b = onehot(buf[rd]^2'b11).
  - Held exactly PRESS cycles, then -> GAP.
- GAP:
  - b=0 for RELEASE cycles.
  - Then rd++. If rd==len: rounds++ (saturating), len=0, -> LISTEN. Otherwise -> PRESS.
- l is ignored outside LISTEN (the game's echo during replay is not recorded).
- HALT:
  - b=0, busy=0. len and rounds hold.
  - Leaves only via en==0 (-> IDLE) or reset.
  - win and lose both high: same as either (HALT).
- Each button press is a clean one-hot pulse of PRESS cycles; b never changes directly between two non-zero values.
- Latency: the first press asserts GAP_END+1 cycles after the last symbol's light falls to 0.

Test Plan:
- Reset/idle: reset=0, then released with en=0 and l toggling -> b=0, len=0, rounds=0, state stays IDLE.
- Single round: en=1; l shows 0100, 0, then 0001, 0 (2 cycles each), then 0 for 4 cycles -> len=2, b = 0100 for 2 cycles, 0 for 2, 0001 for 2, 0 for 2; then rounds=1 and len=0.
- Back-to-back same symbol: l = 0010, 0, 0010, 0 -> len=2; replay is 0010, 0010 with a 2-cycle gap.
- Overflow: 9 alternating symbols 0001/1000 with 0 between -> len=8, ovf=1; replay is 8 presses.
- Error injection: inject_err=1 with sequence {1,3} -> replay b=0010, then 0001 (3^3=0); drive lose=1 -> b=0 next cycle, state HALT; en=0 -> IDLE.
- Async reset mid-press: reset=0 while b=1000 -> b=0 before the next clk edge; all outputs at reset values.
- Malformed lights: l=0110 for 1 cycle -> bad_l=1, len unchanged.
